// File: rtl/sid_i2s_tx.sv
// I2S (Philips) master transmitter for the SID filter's 16-bit mono stream.
// Samples queue in a small FIFO and each one plays on both channels of a 32-slot frame.
module sid_i2s_tx #(
    parameter  int BCLK_DIV   = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [15:0]   sample_in,
    input  logic          sample_valid,
    output logic          i2s_bclk,
    output logic          i2s_lrclk,
    output logic          i2s_sdata,
    output logic [LW-1:0] fifo_level,
    output logic          overflow,
    output logic          underflow
);

    localparam int            DW       = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    logic [DW-1:0] r_div_cnt;
    logic          r_bclk;
    logic          r_lrclk;
    logic          r_sdata;
    logic [4:0]    r_slot;
    logic [15:0]   r_frame;
    logic [15:0]   r_last_sample;
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_div_wrap;
    logic          w_fall_evt;
    logic [4:0]    w_slot_next;
    logic          w_frame_start;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [15:0]   w_frame_next;
    logic [3:0]    w_bit_idx;
    logic          w_lrclk_next;
    logic          w_sdata_next;

    assign w_div_wrap    = (r_div_cnt == DIV_LAST);
    assign w_fall_evt    = w_div_wrap & r_bclk;
    assign w_slot_next   = r_slot + 5'd1;
    assign w_frame_start = w_fall_evt & (w_slot_next == 5'd0);

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    assign w_pop   = w_frame_start & ~w_empty;
    // A full FIFO still accepts a write when the frame start frees a slot in the same cycle.
    assign w_push  = sample_valid & (~w_full | w_pop);

    assign w_frame_next = w_frame_start ? (w_empty ? r_last_sample : r_mem[r_rd_ptr]) : r_frame;
    // Slots 0..15 and 16..31 both walk the frame MSB first, so the low 4 slot bits pick the bit.
    assign w_bit_idx    = 4'd15 - w_slot_next[3:0];
    assign w_sdata_next = w_frame_next[w_bit_idx];
    assign w_lrclk_next = (w_slot_next >= 5'd15) && (w_slot_next <= 5'd30);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_slot        <= 5'd31;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame       <= '0;
            r_last_sample <= '0;
        end else if (w_fall_evt) begin
            r_slot  <= w_slot_next;
            r_lrclk <= w_lrclk_next;
            r_sdata <= w_sdata_next;
            r_frame <= w_frame_next;
            if (w_pop) begin
                r_last_sample <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= sample_in;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= sample_valid & w_full & ~w_pop;
            r_underflow <= w_frame_start & w_empty;
        end
    end

    assign i2s_bclk   = r_bclk;
    assign i2s_lrclk  = r_lrclk;
    assign i2s_sdata  = r_sdata;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Directed bench for sid_i2s_tx with BCLK_DIV=2, FIFO_DEPTH=4.
// Edges are counted from reset release; slot s of a frame starting at edge F is entered at edge F+4*s.
module tb_sid_i2s_tx;

    localparam int BCLK_DIV   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = 3;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic [15:0]   sampleIn = '0;
    logic          sampleValid = 1'b0;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic [LW-1:0] fifoLevel;
    logic          overflow;
    logic          underflow;

    int errors  = 0;
    int checks  = 0;
    int edgeNum = 0;

    sid_i2s_tx #(
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .n_reset      (nReset),
        .sample_in    (sampleIn),
        .sample_valid (sampleValid),
        .i2s_bclk     (bclk),
        .i2s_lrclk    (lrclk),
        .i2s_sdata    (sdata),
        .fifo_level   (fifoLevel),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        edgeNum++;
    endtask

    task automatic gotoEdge(input int e);
        while (edgeNum < e) tick();
    endtask

    task automatic releaseReset;
        @(negedge clk);
        nReset  = 1'b1;
        edgeNum = 0;
    endtask

    task automatic doReset;
        sampleValid = 1'b0;
        sampleIn    = '0;
        nReset      = 1'b0;
        repeat (3) @(posedge clk);
        releaseReset();
    endtask

    // Writes one sample on the next edge.
    task automatic pushSample(input logic [15:0] d);
        sampleValid = 1'b1;
        sampleIn    = d;
        tick();
        sampleValid = 1'b0;
    endtask

    task automatic collectFrame(input int start, output logic [31:0] sd, output logic [31:0] lr);
        sd = '0;
        lr = '0;
        for (int s = 0; s < 32; s++) begin
            gotoEdge(start + 4 * s);
            sd = {sd[30:0], sdata};
            lr = {lr[30:0], lrclk};
        end
    endtask

    task automatic test_reset;
        logic [31:0] sd, lr;
        nReset = 1'b0;
        #3;
        checks++;
        if ({bclk, lrclk, sdata, overflow, underflow, fifoLevel} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b want=00000000", {bclk, lrclk, sdata, overflow, underflow, fifoLevel});
        end
        repeat (2) @(posedge clk);
        releaseReset();
        tick();
        checks++;
        if (bclk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bclk_edge1 got=%b want=0", bclk);
        end
        tick();
        checks++;
        if (bclk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bclk_edge2 got=%b want=1", bclk);
        end
        gotoEdge(4);
        checks++;
        if ({bclk, underflow} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL first_fall got bclk,underflow=%b want=01", {bclk, underflow});
        end
        collectFrame(4, sd, lr);
        checks++;
        if (sd !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL idle_sdata got=%h want=00000000", sd);
        end
        checks++;
        if (lr !== 32'h0001_FFFE) begin
            errors++;
            $display("[TB] FAIL lrclk_pattern got=%h want=0001fffe", lr);
        end
        gotoEdge(132);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_132 got=%b want=1", underflow);
        end
        tick();
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underflow_133 got=%b want=0", underflow);
        end
        gotoEdge(260);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_260 got=%b want=1", underflow);
        end
    endtask

    task automatic test_single;
        logic [31:0] sd, lr;
        doReset();
        pushSample(16'hA5C3);
        gotoEdge(3);
        checks++;
        if (fifoLevel !== 3'd1) begin
            errors++;
            $display("[TB] FAIL single_level_before got=%0d want=1", fifoLevel);
        end
        gotoEdge(4);
        checks++;
        if ({fifoLevel, underflow} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_pop got level,underflow=%b want=0000", {fifoLevel, underflow});
        end
        collectFrame(4, sd, lr);
        checks++;
        if (sd !== 32'hA5C3_A5C3) begin
            errors++;
            $display("[TB] FAIL single_frame got=%h want=a5c3a5c3", sd);
        end
    endtask

    task automatic test_repeat;
        logic [31:0] sd, lr;
        doReset();
        pushSample(16'h8001);
        collectFrame(4, sd, lr);
        checks++;
        if (sd !== 32'h8001_8001) begin
            errors++;
            $display("[TB] FAIL repeat_frame1 got=%h want=80018001", sd);
        end
        gotoEdge(132);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL repeat_underflow got=%b want=1", underflow);
        end
        collectFrame(132, sd, lr);
        checks++;
        if (sd !== 32'h8001_8001) begin
            errors++;
            $display("[TB] FAIL repeat_frame2 got=%h want=80018001", sd);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] sd, lr;
        logic [15:0] vals [5];
        logic [31:0] want;
        vals = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F};
        doReset();
        gotoEdge(9);
        for (int i = 0; i < 5; i++) begin
            pushSample(vals[i]);
            if (i == 3) begin
                checks++;
                if ({fifoLevel, overflow} !== 4'b1000) begin
                    errors++;
                    $display("[TB] FAIL ovf_fourth got level,overflow=%b want=1000", {fifoLevel, overflow});
                end
            end
        end
        checks++;
        if ({fifoLevel, overflow} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL ovf_fifth got level,overflow=%b want=1001", {fifoLevel, overflow});
        end
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_pulse_width got=%b want=0", overflow);
        end
        for (int f = 0; f < 4; f++) begin
            collectFrame(132 + 128 * f, sd, lr);
            want = {vals[f], vals[f]};
            checks++;
            if (sd !== want) begin
                errors++;
                $display("[TB] FAIL ovf_frame%0d got=%h want=%h", f + 1, sd, want);
            end
        end
        gotoEdge(644);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_drain_underflow got=%b want=1", underflow);
        end
        collectFrame(644, sd, lr);
        checks++;
        if (sd !== 32'hDEF0_DEF0) begin
            errors++;
            $display("[TB] FAIL ovf_repeat_last got=%h want=def0def0", sd);
        end
    endtask

    task automatic test_full_pop;
        logic [31:0] sd, lr;
        doReset();
        gotoEdge(9);
        pushSample(16'h1001);
        pushSample(16'h2002);
        pushSample(16'h3003);
        pushSample(16'h4004);
        gotoEdge(131);
        pushSample(16'hBEEF);
        checks++;
        if ({fifoLevel, overflow, underflow} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL fullpop_level got level,overflow,underflow=%b want=10000", {fifoLevel, overflow, underflow});
        end
        collectFrame(132, sd, lr);
        checks++;
        if (sd !== 32'h1001_1001) begin
            errors++;
            $display("[TB] FAIL fullpop_frame1 got=%h want=10011001", sd);
        end
        gotoEdge(516);
        checks++;
        if (fifoLevel !== 3'd1) begin
            errors++;
            $display("[TB] FAIL fullpop_level_516 got=%0d want=1", fifoLevel);
        end
        collectFrame(644, sd, lr);
        checks++;
        if (sd !== 32'hBEEF_BEEF) begin
            errors++;
            $display("[TB] FAIL fullpop_frame5 got=%h want=beefbeef", sd);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] sd, lr;
        doReset();
        pushSample(16'hFFFF);
        gotoEdge(4);
        pushSample(16'h0101);
        pushSample(16'h0202);
        pushSample(16'h0303);
        gotoEdge(42);
        checks++;
        if ({bclk, sdata, fifoLevel} !== 5'b11011) begin
            errors++;
            $display("[TB] FAIL midrst_before got bclk,sdata,level=%b want=11011", {bclk, sdata, fifoLevel});
        end
        #2;
        nReset = 1'b0;
        #1;
        checks++;
        if ({bclk, lrclk, sdata, fifoLevel} !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL midrst_async got bclk,lrclk,sdata,level=%b want=000000", {bclk, lrclk, sdata, fifoLevel});
        end
        repeat (2) @(posedge clk);
        releaseReset();
        gotoEdge(2);
        checks++;
        if (bclk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_bclk_edge2 got=%b want=1", bclk);
        end
        gotoEdge(4);
        checks++;
        if ({underflow, fifoLevel} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL midrst_restart got underflow,level=%b want=1000", {underflow, fifoLevel});
        end
        collectFrame(4, sd, lr);
        checks++;
        if (sd !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL midrst_frame got=%h want=00000000", sd);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
